srio_db_initiator: RTL and testbench

Initiator-side RapidIO logical-layer request block. After link-up it runs a doorbell self-check against the far endpoint, then accepts an NWRITE request and forwards one user payload stream as a single NWRITE packet on the ireq AXI4-Stream. Packets use the HELLO beat format. The block sits between user logic and the SRIO core's ireq/iresp ports.

---
 rtl/srio_db_initiator.sv | 212 +++++++++++++++++++++
 tb/tb_srio_db_initiator.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/srio_db_initiator.sv
// srio_db_initiator: RapidIO initiator request block.
// After link-up it performs a doorbell self-check against the far endpoint.
// Once that check passes, it forwards one user payload stream per request as
// a single HELLO-format NWRITE packet on the ireq AXI4-Stream.
module srio_db_initiator #(
    parameter logic [15:0] DB_INFO_CHECK = 16'h0001,
    parameter int unsigned MAX_BYTES     = 256
) (
    input  logic        log_clk,
    input  logic        log_rst,
    input  logic [15:0] src_id,
    input  logic [15:0] des_id,
    input  logic        self_check_in,
    input  logic        nwr_req_in,
    input  logic        link_initialized,
    output logic        rapidIO_ready_o,
    output logic        nwr_ready_o,
    output logic        nwr_busy_o,
    output logic        go,
    input  logic [33:0] user_addr,
    input  logic [3:0]  user_ftype,
    input  logic [3:0]  user_ttype,
    input  logic [63:0] user_tdata_in,
    input  logic        user_tvalid_in,
    input  logic [7:0]  user_tkeep_in,
    input  logic        user_tlast_in,
    input  logic [11:0] user_tsize_in,
    output logic        user_tready_o,
    output logic        ireq_tvalid_o,
    input  logic        ireq_tready_in,
    output logic        ireq_tlast_o,
    output logic [63:0] ireq_tdata_o,
    output logic [7:0]  ireq_tkeep_o,
    output logic [31:0] ireq_tuser_o,
    input  logic        iresp_tvalid_in,
    output logic        iresp_tready_o,
    input  logic        iresp_tlast_in,
    input  logic [63:0] iresp_tdata_in,
    input  logic [7:0]  iresp_tkeep_in,
    input  logic [31:0] iresp_tuser_in
);

    localparam int unsigned TID_W   = 8;
    localparam int unsigned SIZE_W  = 8;
    localparam int unsigned TSIZE_W = 12;

    localparam logic [3:0] FTYPE_NWRITE   = 4'h5;
    localparam logic [3:0] TTYPE_NWRITE   = 4'h4;
    localparam logic [3:0] FTYPE_DOORBELL = 4'hA;
    localparam logic [3:0] TTYPE_DOORBELL = 4'h0;
    localparam logic [3:0] FTYPE_RESP     = 4'hD;
    localparam logic [3:0] TTYPE_RESP     = 4'h0;
    localparam logic [3:0] STATUS_DONE    = 4'h0;
    localparam logic [1:0] PRIO           = 2'b01;
    localparam logic       CRF            = 1'b0;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_DB_SEND  = 3'd1,
        S_DB_WAIT  = 3'd2,
        S_READY    = 3'd3,
        S_NWR_HDR  = 3'd4,
        S_NWR_DATA = 3'd5
    } state_t;

    state_t             r_state;
    logic [TID_W-1:0]   r_tid;
    logic [TID_W-1:0]   r_db_tid;
    logic               r_rapidio_ready;
    logic               r_iresp_tready;
    logic               r_nwr_ready;
    logic               r_nwr_busy;
    logic               r_go;
    logic               r_ireq_tvalid;
    logic               r_ireq_tlast;
    logic [63:0]        r_ireq_tdata;
    logic [7:0]         r_ireq_tkeep;
    logic [31:0]        r_ireq_tuser;

    logic [63:0]        w_db_hdr;
    logic [63:0]        w_nwr_hdr;
    logic [SIZE_W-1:0]  w_nwr_size;
    logic               w_size_ok;
    logic               w_resp_match;
    logic               w_resp_done;
    logic               w_data_phase;
    logic               w_last_accept;
    logic               w_unused;

    // Header beats built from the current TID; loaded into the ireq registers on entry.
    assign w_db_hdr   = {r_tid, FTYPE_DOORBELL, TTYPE_DOORBELL, 1'b0, PRIO, CRF,
                         8'h00, 4'h0, DB_INFO_CHECK, 16'h0000};
    assign w_nwr_size = SIZE_W'(user_tsize_in - TSIZE_W'(1));
    assign w_nwr_hdr  = {r_tid, FTYPE_NWRITE, TTYPE_NWRITE, 1'b0, PRIO, CRF,
                         w_nwr_size, 2'b00, user_addr};

    // Payload length must be 1..MAX_BYTES for the request to be taken.
    assign w_size_ok = (user_tsize_in != '0) && (32'(user_tsize_in) <= MAX_BYTES);

    // A response beat counts only if it is a response type carrying our doorbell TID.
    assign w_resp_match = iresp_tvalid_in && r_iresp_tready
                       && (iresp_tdata_in[55:52] == FTYPE_RESP)
                       && (iresp_tdata_in[51:48] == TTYPE_RESP)
                       && (iresp_tdata_in[63:56] == r_db_tid);
    assign w_resp_done  = (iresp_tdata_in[43:40] == STATUS_DONE);

    assign w_data_phase  = (r_state == S_NWR_DATA);
    assign w_last_accept = user_tvalid_in && ireq_tready_in && user_tlast_in;

    // Fields and sideband we deliberately do not interpret.
    assign w_unused = ^{user_ftype, user_ttype, iresp_tlast_in, iresp_tkeep_in,
                        iresp_tuser_in, iresp_tdata_in[47:44], iresp_tdata_in[39:0]};

    // Control FSM with registered status flags and ireq header registers.
    always_ff @(posedge log_clk) begin
        if (log_rst) begin
            r_state         <= S_IDLE;
            r_tid           <= '0;
            r_db_tid        <= '0;
            r_rapidio_ready <= 1'b0;
            r_iresp_tready  <= 1'b0;
            r_nwr_ready     <= 1'b0;
            r_nwr_busy      <= 1'b0;
            r_go            <= 1'b0;
            r_ireq_tvalid   <= 1'b0;
            r_ireq_tlast    <= 1'b0;
            r_ireq_tdata    <= '0;
            r_ireq_tkeep    <= '0;
            r_ireq_tuser    <= '0;
        end else begin
            r_rapidio_ready <= link_initialized;
            r_iresp_tready  <= 1'b1;
            r_go            <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (self_check_in && r_rapidio_ready) begin
                        r_state       <= S_DB_SEND;
                        r_db_tid      <= r_tid;
                        r_ireq_tvalid <= 1'b1;
                        r_ireq_tlast  <= 1'b1;
                        r_ireq_tdata  <= w_db_hdr;
                        r_ireq_tkeep  <= 8'hFF;
                        r_ireq_tuser  <= {src_id, des_id};
                    end
                end
                S_DB_SEND: begin
                    if (ireq_tready_in) begin
                        r_state       <= S_DB_WAIT;
                        r_ireq_tvalid <= 1'b0;
                        r_ireq_tlast  <= 1'b0;
                        r_tid         <= r_tid + TID_W'(1);
                    end
                end
                S_DB_WAIT: begin
                    if (w_resp_match) begin
                        if (w_resp_done) begin
                            r_state     <= S_READY;
                            r_nwr_ready <= 1'b1;
                        end else begin
                            r_state     <= S_IDLE;
                        end
                    end
                end
                S_READY: begin
                    if (nwr_req_in && w_size_ok) begin
                        r_state       <= S_NWR_HDR;
                        r_nwr_ready   <= 1'b0;
                        r_nwr_busy    <= 1'b1;
                        r_ireq_tvalid <= 1'b1;
                        r_ireq_tlast  <= 1'b0;
                        r_ireq_tdata  <= w_nwr_hdr;
                        r_ireq_tkeep  <= 8'hFF;
                        r_ireq_tuser  <= {src_id, des_id};
                    end
                end
                S_NWR_HDR: begin
                    if (ireq_tready_in) begin
                        r_state       <= S_NWR_DATA;
                        r_ireq_tvalid <= 1'b0;
                        r_go          <= 1'b1;
                        r_tid         <= r_tid + TID_W'(1);
                    end
                end
                S_NWR_DATA: begin
                    if (w_last_accept) begin
                        r_state     <= S_READY;
                        r_nwr_busy  <= 1'b0;
                        r_nwr_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // During the data phase the user stream is passed straight through to ireq.
    assign ireq_tvalid_o = w_data_phase ? user_tvalid_in : r_ireq_tvalid;
    assign ireq_tlast_o  = w_data_phase ? user_tlast_in  : r_ireq_tlast;
    assign ireq_tdata_o  = w_data_phase ? user_tdata_in  : r_ireq_tdata;
    assign ireq_tkeep_o  = w_data_phase ? user_tkeep_in  : r_ireq_tkeep;
    assign ireq_tuser_o  = r_ireq_tuser;
    assign user_tready_o = w_data_phase & ireq_tready_in;

    assign rapidIO_ready_o = r_rapidio_ready;
    assign iresp_tready_o  = r_iresp_tready;
    assign nwr_ready_o     = r_nwr_ready;
    assign nwr_busy_o      = r_nwr_busy;
    assign go              = r_go;

endmodule

// File: tb/tb_srio_db_initiator.sv
// Bench for srio_db_initiator: directed doorbell sequences, a table of NWRITE
// requests, randomized NWRITEs with back-pressure, and a mid-packet reset.
module tb_srio_db_initiator;

    localparam logic [15:0] SRC_ID  = 16'h0001;
    localparam logic [15:0] DES_ID  = 16'h00F0;
    localparam logic [15:0] DB_INFO = 16'h0001;
    localparam int unsigned MAX_B   = 256;

    typedef struct { logic [63:0] d; logic [7:0] k; logic l; } beat_t;
    typedef struct { logic [33:0] addr; logic [11:0] tsize; bit accept; } nwr_vec_t;

    logic        log_clk = 1'b0;
    logic        log_rst;
    logic [15:0] src_id;
    logic [15:0] des_id;
    logic        self_check_in;
    logic        nwr_req_in;
    logic        link_initialized;
    logic        rapidIO_ready_o;
    logic        nwr_ready_o;
    logic        nwr_busy_o;
    logic        go;
    logic [33:0] user_addr;
    logic [3:0]  user_ftype;
    logic [3:0]  user_ttype;
    logic [63:0] user_tdata_in;
    logic        user_tvalid_in;
    logic [7:0]  user_tkeep_in;
    logic        user_tlast_in;
    logic [11:0] user_tsize_in;
    logic        user_tready_o;
    logic        ireq_tvalid_o;
    logic        ireq_tready_in;
    logic        ireq_tlast_o;
    logic [63:0] ireq_tdata_o;
    logic [7:0]  ireq_tkeep_o;
    logic [31:0] ireq_tuser_o;
    logic        iresp_tvalid_in;
    logic        iresp_tready_o;
    logic        iresp_tlast_in;
    logic [63:0] iresp_tdata_in;
    logic [7:0]  iresp_tkeep_in;
    logic [31:0] iresp_tuser_in;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [7:0]  m_tid;
    nwr_vec_t    vecs[8];

    srio_db_initiator #(.DB_INFO_CHECK(DB_INFO), .MAX_BYTES(MAX_B)) dut (
        .log_clk(log_clk), .log_rst(log_rst), .src_id(src_id), .des_id(des_id),
        .self_check_in(self_check_in), .nwr_req_in(nwr_req_in),
        .link_initialized(link_initialized), .rapidIO_ready_o(rapidIO_ready_o),
        .nwr_ready_o(nwr_ready_o), .nwr_busy_o(nwr_busy_o), .go(go),
        .user_addr(user_addr), .user_ftype(user_ftype), .user_ttype(user_ttype),
        .user_tdata_in(user_tdata_in), .user_tvalid_in(user_tvalid_in),
        .user_tkeep_in(user_tkeep_in), .user_tlast_in(user_tlast_in),
        .user_tsize_in(user_tsize_in), .user_tready_o(user_tready_o),
        .ireq_tvalid_o(ireq_tvalid_o), .ireq_tready_in(ireq_tready_in),
        .ireq_tlast_o(ireq_tlast_o), .ireq_tdata_o(ireq_tdata_o),
        .ireq_tkeep_o(ireq_tkeep_o), .ireq_tuser_o(ireq_tuser_o),
        .iresp_tvalid_in(iresp_tvalid_in), .iresp_tready_o(iresp_tready_o),
        .iresp_tlast_in(iresp_tlast_in), .iresp_tdata_in(iresp_tdata_in),
        .iresp_tkeep_in(iresp_tkeep_in), .iresp_tuser_in(iresp_tuser_in)
    );

    always #5 log_clk = ~log_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // HELLO header composed field by field from its bit positions.
    function automatic logic [63:0] hdr(input logic [7:0] tid, input logic [3:0] ft,
                                        input logic [3:0] tt, input logic [7:0] size,
                                        input logic [33:0] addr);
        return (64'(tid) << 56) | (64'(ft) << 52) | (64'(tt) << 48) | (64'd1 << 45)
             | (64'(size) << 36) | 64'(addr);
    endfunction

    function automatic logic [63:0] resp(input logic [7:0] tid, input logic [3:0] st);
        return (64'(tid) << 56) | (64'hD << 52) | (64'(st) << 40);
    endfunction

    task automatic apply_reset();
        log_rst = 1'b1;
        @(negedge log_clk);
        chk("rst_ctrl", 64'({rapidIO_ready_o, nwr_ready_o, nwr_busy_o, go, user_tready_o,
                              ireq_tvalid_o, ireq_tlast_o, iresp_tready_o}), 64'(0));
        chk("rst_tdata", ireq_tdata_o, 64'(0));
        chk("rst_keep_user", 64'({ireq_tkeep_o, ireq_tuser_o}), 64'(0));
        self_check_in = 1'b0; nwr_req_in = 1'b0; user_tvalid_in = 1'b0;
        user_tlast_in = 1'b0; ireq_tready_in = 1'b0; iresp_tvalid_in = 1'b0;
        @(negedge log_clk);
        log_rst = 1'b0;
        @(negedge log_clk);
        chk("iresp_tready_after_rst", 64'(iresp_tready_o), 64'(1));
        m_tid = 8'h00;
    endtask

    task automatic do_db(input logic [3:0] status, input int hold);
        logic [7:0]  t;
        logic [63:0] eh;
        eh = hdr(m_tid, 4'hA, 4'h0, 8'h00, 34'({DB_INFO, 16'h0000}));
        @(negedge log_clk); self_check_in = 1'b1;
        @(negedge log_clk); self_check_in = 1'b0;
        chk("db_valid", 64'(ireq_tvalid_o), 64'(1));
        chk("db_hdr", ireq_tdata_o, eh);
        chk("db_type", 64'(ireq_tdata_o[55:48]), 64'(8'hA0));
        chk("db_info", 64'(ireq_tdata_o[31:16]), 64'(DB_INFO));
        chk("db_last", 64'(ireq_tlast_o), 64'(1));
        chk("db_keep", 64'(ireq_tkeep_o), 64'(8'hFF));
        chk("db_tuser", 64'(ireq_tuser_o), 64'({SRC_ID, DES_ID}));
        for (int i = 0; i < hold; i++) begin
            @(negedge log_clk);
            chk("db_hold_valid", 64'(ireq_tvalid_o), 64'(1));
            chk("db_hold_data", ireq_tdata_o, eh);
        end
        ireq_tready_in = 1'b1;
        @(negedge log_clk); ireq_tready_in = 1'b0;
        chk("db_sent_valid", 64'(ireq_tvalid_o), 64'(0));
        t = m_tid;
        m_tid++;
        iresp_tvalid_in = 1'b1; iresp_tdata_in = resp(t + 8'd1, 4'h0);
        @(negedge log_clk); iresp_tvalid_in = 1'b0;
        chk("db_stray_ignored", 64'(nwr_ready_o), 64'(0));
        iresp_tvalid_in = 1'b1; iresp_tdata_in = resp(t, status);
        @(negedge log_clk); iresp_tvalid_in = 1'b0;
        chk("db_result_ready", 64'(nwr_ready_o), 64'(status == 4'h0));
        @(negedge log_clk);
        chk("db_result_hold", 64'(nwr_ready_o), 64'(status == 4'h0));
        chk("db_result_busy", 64'(nwr_busy_o), 64'(0));
    endtask

    task automatic run_nwr(input logic [33:0] addr, input logic [11:0] tsize, input bit accept,
                           input int stall_at, input bit rand_bp);
        beat_t       expq[$];
        beat_t       userq[$];
        beat_t       b;
        int          nbeats, rem, cyc, dcyc, gos;
        bit          dphase, acc_prev, pv;
        logic [63:0] pd;
        @(negedge log_clk);
        nwr_req_in = 1'b1; user_addr = addr; user_tsize_in = tsize;
        @(negedge log_clk);
        nwr_req_in = 1'b0;
        user_addr = 34'({$urandom, $urandom});
        user_tsize_in = 12'($urandom);
        if (!accept) begin
            chk("rej_valid", 64'(ireq_tvalid_o), 64'(0));
            chk("rej_ready", 64'(nwr_ready_o), 64'(1));
            chk("rej_busy", 64'(nwr_busy_o), 64'(0));
            @(negedge log_clk);
            chk("rej_valid2", 64'(ireq_tvalid_o), 64'(0));
            chk("rej_ready2", 64'(nwr_ready_o), 64'(1));
            return;
        end
        chk("hdr_latency", 64'(ireq_tvalid_o), 64'(1));
        chk("busy_rise", 64'(nwr_busy_o), 64'(1));
        chk("ready_fall", 64'(nwr_ready_o), 64'(0));
        b.d = hdr(m_tid, 4'h5, 4'h4, 8'(tsize - 12'd1), addr);
        b.k = 8'hFF; b.l = 1'b0;
        expq.push_back(b);
        nbeats = (int'(tsize) + 7) / 8;
        for (int i = 0; i < nbeats; i++) begin
            b.d = {$urandom, $urandom};
            b.l = (i == nbeats - 1);
            rem = int'(tsize) - 8 * i;
            b.k = (rem >= 8) ? 8'hFF : 8'((16'd1 << rem) - 16'd1);
            userq.push_back(b);
            expq.push_back(b);
        end
        cyc = 0; dcyc = 0; gos = 0; dphase = 1'b0; acc_prev = 1'b0; pv = 1'b0; pd = '0;
        while (expq.size() > 0 && cyc < 4000) begin
            if (dphase && userq.size() > 0) begin
                if (acc_prev || !user_tvalid_in)
                    user_tvalid_in = rand_bp ? ($urandom_range(0, 3) != 0) : 1'b1;
                user_tdata_in = userq[0].d; user_tkeep_in = userq[0].k; user_tlast_in = userq[0].l;
            end else begin
                user_tvalid_in = 1'b0; user_tlast_in = 1'b0;
            end
            if (dphase && stall_at >= 0 && dcyc >= stall_at && dcyc < stall_at + 3)
                ireq_tready_in = 1'b0;
            else if (rand_bp)
                ireq_tready_in = 1'($urandom_range(0, 1));
            else
                ireq_tready_in = 1'b1;
            #1;
            if (go) gos++;
            if (pv) begin
                chk("hold_valid", 64'(ireq_tvalid_o), 64'(1));
                chk("hold_data", ireq_tdata_o, pd);
            end
            chk("user_tready", 64'(user_tready_o), 64'(dphase ? ireq_tready_in : 1'b0));
            chk("busy_during", 64'(nwr_busy_o), 64'(1));
            acc_prev = 1'b0;
            if (ireq_tvalid_o && ireq_tready_in) begin
                chk("beat_data", ireq_tdata_o, expq[0].d);
                chk("beat_keep", 64'(ireq_tkeep_o), 64'(expq[0].k));
                chk("beat_last", 64'(ireq_tlast_o), 64'(expq[0].l));
                chk("beat_tuser", 64'(ireq_tuser_o), 64'({SRC_ID, DES_ID}));
                void'(expq.pop_front());
                if (dphase) begin
                    void'(userq.pop_front());
                    acc_prev = 1'b1;
                end else begin
                    dphase = 1'b1;
                    m_tid++;
                end
                pv = 1'b0;
            end else begin
                pv = ireq_tvalid_o;
                pd = ireq_tdata_o;
            end
            if (dphase) dcyc++;
            @(negedge log_clk);
            cyc++;
        end
        chk("nwr_beats_left", 64'(expq.size()), 64'(0));
        user_tvalid_in = 1'b0; user_tlast_in = 1'b0; ireq_tready_in = 1'b0;
        chk("busy_fall", 64'(nwr_busy_o), 64'(0));
        chk("ready_return", 64'(nwr_ready_o), 64'(1));
        chk("go_count", 64'(gos), 64'(1));
    endtask

    initial begin
        logic [11:0] ts;
        log_rst = 1'b1; src_id = SRC_ID; des_id = DES_ID;
        self_check_in = 1'b0; nwr_req_in = 1'b0; link_initialized = 1'b0;
        user_addr = '0; user_ftype = 4'h3; user_ttype = 4'h9; user_tdata_in = '0;
        user_tvalid_in = 1'b0; user_tkeep_in = '0; user_tlast_in = 1'b0; user_tsize_in = '0;
        ireq_tready_in = 1'b0; iresp_tvalid_in = 1'b0; iresp_tlast_in = 1'b1;
        iresp_tdata_in = '0; iresp_tkeep_in = 8'hFF; iresp_tuser_in = '0;
        m_tid = 8'h00;

        vecs[0] = '{34'h0_0000_2000, 12'd0,    1'b0};
        vecs[1] = '{34'h0_0000_2000, 12'd300,  1'b0};
        vecs[2] = '{34'h0_0000_3000, 12'd257,  1'b0};
        vecs[3] = '{34'h0_0000_3000, 12'd4095, 1'b0};
        vecs[4] = '{34'h3_FFFF_FFF8, 12'd1,    1'b1};
        vecs[5] = '{34'h0_0000_0000, 12'd256,  1'b1};
        vecs[6] = '{34'h1_2345_6780, 12'd8,    1'b1};
        vecs[7] = '{34'h0_0000_4444, 12'd9,    1'b1};

        apply_reset();

        // Self-check request while the link is down must be ignored.
        @(negedge log_clk); self_check_in = 1'b1;
        @(negedge log_clk); self_check_in = 1'b0;
        chk("linkdown_no_db", 64'(ireq_tvalid_o), 64'(0));
        chk("linkdown_rdy", 64'(rapidIO_ready_o), 64'(0));
        @(negedge log_clk);
        chk("linkdown_no_db2", 64'(ireq_tvalid_o), 64'(0));

        link_initialized = 1'b1;
        #1 chk("rdy_lag0", 64'(rapidIO_ready_o), 64'(0));
        @(negedge log_clk);
        chk("rdy_lag1", 64'(rapidIO_ready_o), 64'(1));

        do_db(4'h0, 2);

        // Self-check pulse in READY is ignored.
        @(negedge log_clk); self_check_in = 1'b1;
        @(negedge log_clk); self_check_in = 1'b0;
        chk("ready_selfchk_ignored", 64'(ireq_tvalid_o), 64'(0));
        chk("ready_selfchk_rdy", 64'(nwr_ready_o), 64'(1));

        run_nwr(34'h0_0000_1000, 12'd32, 1'b1, 2, 1'b0);

        for (int i = 0; i < 8; i++)
            run_nwr(vecs[i].addr, vecs[i].tsize, vecs[i].accept, -1, 1'b0);

        // Random NWRITEs with back-pressure while the link indication is down.
        link_initialized = 1'b0;
        for (int i = 0; i < 20; i++) begin
            ts = 12'($urandom_range(0, 300));
            run_nwr(34'({$urandom, $urandom}), ts, (ts != 12'd0) && (int'(ts) <= int'(MAX_B)),
                    -1, 1'b1);
        end
        link_initialized = 1'b1;

        // Reset in the middle of a payload.
        @(negedge log_clk);
        nwr_req_in = 1'b1; user_addr = 34'h2_0000_0000; user_tsize_in = 12'd64;
        @(negedge log_clk);
        nwr_req_in = 1'b0; ireq_tready_in = 1'b1;
        @(negedge log_clk);
        m_tid++;
        user_tvalid_in = 1'b1; user_tdata_in = 64'hDEAD_BEEF_0000_0001;
        user_tkeep_in = 8'hFF; user_tlast_in = 1'b0;
        #1;
        chk("mid_busy", 64'(nwr_busy_o), 64'(1));
        chk("mid_user_tready", 64'(user_tready_o), 64'(1));
        chk("mid_pass_data", ireq_tdata_o, 64'hDEAD_BEEF_0000_0001);
        @(negedge log_clk);
        apply_reset();

        // After reset an NWRITE request is not accepted until a new self-check.
        @(negedge log_clk);
        nwr_req_in = 1'b1; user_tsize_in = 12'd16;
        @(negedge log_clk);
        nwr_req_in = 1'b0;
        chk("post_rst_no_nwr", 64'(ireq_tvalid_o), 64'(0));
        chk("post_rst_not_ready", 64'(nwr_ready_o), 64'(0));

        do_db(4'h7, 1);
        do_db(4'h0, 0);
        run_nwr(34'h0_0000_ABC0, 12'd20, 1'b1, 0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
